irq_controller: RTL and testbench

Memory-mapped interrupt controller between the SoC's interrupt sources (GP timer, UART rx, Econet rx frame, Econet timer A, SD card detect) and the FemtoRV32 `interrupt_request` input. It replaces the plain OR of sources. It latches edge- or level-type requests, applies a per-source enable mask and arbitrates among pending sources. The CPU takes one interrupt at a time through a claim/complete handshake. It sits on the CPU bus like the other peripherals, on a 16-byte select window.

---
 rtl/irq_controller_if.sv | 13 +
 rtl/irq_controller.sv | 187 ++++++++++++++++++
 tb/tb_irq_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Register-window bus between the CPU interconnect and irq_controller.
// The master drives select/addr/we/rd/wdata; the slave returns registered rdata.
interface irq_controller_if;
    logic        select;
    logic [1:0]  addr;
    logic [3:0]  we;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output select, addr, we, rd, wdata, input rdata);
    modport slave  (input select, addr, we, rd, wdata, output rdata);
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge/level latching, enable mask, arbitration, claim/complete.
// Optional macro IRQ_ROTATE_PRIORITY_EN selects round-robin instead of lowest-index-first arbitration.
module irq_controller #(
    parameter int NUM_SRC = 8
) (
    input  logic                input_clk,
    input  logic                reset,
    irq_controller_if.slave     bus,
    input  logic [NUM_SRC-1:0]  src,
    output logic                cpu_irq
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_IN_SERVICE = 1'b1} state_e;

    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_ENABLE  = 2'd1;
    localparam logic [1:0] A_CLAIM   = 2'd2;
    localparam logic [1:0] A_MODE    = 2'd3;

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] src_q, edge_pend_q, edge_pend_d;
    logic [NUM_SRC-1:0] enable_q, enable_d, mode_q, mode_d;
    logic [4:0]         svc_idx_q, svc_idx_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               cpu_irq_q;
    logic [NUM_SRC-1:0] pending_s, cand_s, rise_s, claim_clr_s, w1c_s;
    logic [31:0]        wmask_s;
    logic [4:0]         winner_s;
    logic               wr_s, rd_s, take_s, done_s;
    logic               unused_s;

    assign wr_s      = bus.select && (bus.we != 4'd0);
    assign rd_s      = bus.select && bus.rd;
    assign wmask_s   = lane_mask(bus.we);
    // Edge bits come from the latch, level bits follow the registered line directly.
    assign pending_s = (mode_q & edge_pend_q) | (~mode_q & src_q);
    assign cand_s    = pending_s & enable_q;
    assign take_s    = (state_q == ST_IDLE) && rd_s && (bus.addr == A_CLAIM) && (cand_s != '0);
    assign done_s    = (state_q == ST_IN_SERVICE) && wr_s && bus.we[0] &&
                       (bus.addr == A_CLAIM) && (bus.wdata[4:0] == svc_idx_q);

`ifdef IRQ_ROTATE_PRIORITY_EN
    logic [4:0]           rr_ptr_q, rr_ptr_d;
    logic [2*NUM_SRC-1:0] dbl_s;
    logic [5:0]           pos_s, sum_s;

    // Round-robin winner: rotate the candidate set so the search starts at rr_ptr.
    always_comb begin
        dbl_s = {cand_s, cand_s} >> rr_ptr_q;
        pos_s = 6'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            pos_s = dbl_s[k] ? 6'(k) : pos_s;
        end
        sum_s    = {1'b0, rr_ptr_q} + pos_s;
        sum_s    = (sum_s >= 6'(NUM_SRC)) ? (sum_s - 6'(NUM_SRC)) : sum_s;
        winner_s = sum_s[4:0];
    end

    // Pointer advances past the source just completed.
    always_comb begin
        if (done_s) begin
            rr_ptr_d = (svc_idx_q == 5'(NUM_SRC - 1)) ? 5'd0 : (svc_idx_q + 5'd1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Rotation pointer register.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= 5'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign unused_s = ^{bus.wdata, wmask_s, dbl_s, sum_s};
`else
    // Fixed priority winner: lowest candidate index.
    always_comb begin
        winner_s = 5'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            winner_s = cand_s[k] ? 5'(k) : winner_s;
        end
    end

    assign unused_s = ^{bus.wdata, wmask_s};
`endif

    // Claim/complete state machine.
    always_comb begin
        state_d   = state_q;
        svc_idx_d = svc_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (take_s) begin
                    state_d   = ST_IN_SERVICE;
                    svc_idx_d = winner_s;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_IN_SERVICE: begin
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IN_SERVICE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register-file updates; an edge event beats a same-cycle W1C or claim clear.
    always_comb begin
        claim_clr_s = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            claim_clr_s[k] = take_s && (winner_s == 5'(k));
        end
        rise_s = src & ~src_q;
        w1c_s  = (wr_s && (bus.addr == A_PENDING)) ? (bus.wdata[NUM_SRC-1:0] & wmask_s[NUM_SRC-1:0]) : '0;
        if (wr_s && (bus.addr == A_ENABLE)) begin
            enable_d = (enable_q & ~wmask_s[NUM_SRC-1:0]) | (bus.wdata[NUM_SRC-1:0] & wmask_s[NUM_SRC-1:0]);
        end else begin
            enable_d = enable_q;
        end
        if (wr_s && (bus.addr == A_MODE)) begin
            mode_d = (mode_q & ~wmask_s[NUM_SRC-1:0]) | (bus.wdata[NUM_SRC-1:0] & wmask_s[NUM_SRC-1:0]);
        end else begin
            mode_d = mode_q;
        end
        edge_pend_d = ((edge_pend_q & ~w1c_s & ~claim_clr_s) | rise_s) & mode_d;
    end

    // Read mux, sampled with pre-edge state.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_s) begin
            case (bus.addr)
                A_PENDING: rdata_d = 32'(pending_s);
                A_ENABLE:  rdata_d = 32'(enable_q);
                A_CLAIM: begin
                    if (state_q == ST_IN_SERVICE) begin
                        rdata_d = {1'b1, 26'd0, svc_idx_q};
                    end else if (cand_s != '0) begin
                        rdata_d = {1'b1, 26'd0, winner_s};
                    end else begin
                        rdata_d = 32'd0;
                    end
                end
                A_MODE:    rdata_d = 32'(mode_q);
                default:   rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and register storage.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            edge_pend_q <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            svc_idx_q   <= 5'd0;
            rdata_q     <= 32'd0;
            cpu_irq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src;
            edge_pend_q <= edge_pend_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            svc_idx_q   <= svc_idx_d;
            rdata_q     <= rdata_d;
            cpu_irq_q   <= (state_q == ST_IDLE) && (cand_s != '0);
        end
    end

    assign bus.rdata = rdata_q;
    assign cpu_irq   = cpu_irq_q;
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: spec-level model compared every cycle plus directed literal checks.
// Build with +define+IRQ_ROTATE_PRIORITY_EN to exercise the round-robin variant.
module tb_irq_controller;
    localparam int N = 8;

    logic         input_clk;
    logic         reset;
    logic [N-1:0] src;
    logic         cpu_irq;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [31:0]  rd_val;

    irq_controller_if bus();

    irq_controller #(.NUM_SRC(N)) dut (
        .input_clk (input_clk),
        .reset     (reset),
        .bus       (bus),
        .src       (src),
        .cpu_irq   (cpu_irq)
    );

    initial begin
        input_clk = 1'b0;
        forever #5 input_clk = ~input_clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Spec-level model: plain integers, one update per rising edge.
    int unsigned m_en, m_mode, m_epend, m_srcq, m_svc, m_rr;
    bit          m_busy, m_irq;
    logic [31:0] m_rdata;
    localparam int unsigned NMASK = (1 << N) - 1;

    function automatic int pick(input int unsigned cand, input int unsigned start);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(start) + k) % N;
            if (cand[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic int unsigned lanes(input logic [3:0] we);
        int unsigned m;
        m = 0;
        for (int b = 0; b < 4; b++) if (we[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    always @(posedge input_clk or posedge reset) begin
        if (reset) begin
            m_en = 0; m_mode = 0; m_epend = 0; m_srcq = 0; m_svc = 0; m_rr = 0;
            m_busy = 1'b0; m_irq = 1'b0; m_rdata = 32'd0;
        end else begin
            int unsigned pend, cand, wm, clr, rise, sn;
            int          w;
            bit          wr;
            sn   = 32'(src);
            pend = ((m_mode & m_epend) | (~m_mode & m_srcq)) & NMASK;
            cand = pend & m_en;
`ifdef IRQ_ROTATE_PRIORITY_EN
            w = pick(cand, m_rr);
`else
            w = pick(cand, 0);
`endif
            m_irq = !m_busy && (cand != 0);
            wm  = lanes(bus.we);
            wr  = bus.select && (bus.we != 4'd0);
            clr = 0;
            if (bus.select && bus.rd) begin
                case (bus.addr)
                    2'd0:    m_rdata = pend;
                    2'd1:    m_rdata = m_en;
                    2'd2:    m_rdata = m_busy ? (32'h8000_0000 | m_svc) : (cand != 0 ? (32'h8000_0000 | w) : 32'd0);
                    default: m_rdata = m_mode;
                endcase
            end
            if (!m_busy && bus.select && bus.rd && bus.addr == 2'd2 && cand != 0) begin
                m_busy = 1'b1; m_svc = w; clr = 1 << w;
            end else if (m_busy && wr && bus.we[0] && bus.addr == 2'd2 && bus.wdata[4:0] == m_svc[4:0]) begin
                m_busy = 1'b0; m_rr = (m_svc + 1) % N;
            end
            if (wr && bus.addr == 2'd0) clr = clr | (bus.wdata & wm);
            if (wr && bus.addr == 2'd1) m_en   = ((m_en   & ~wm) | (bus.wdata & wm)) & NMASK;
            if (wr && bus.addr == 2'd3) m_mode = ((m_mode & ~wm) | (bus.wdata & wm)) & NMASK;
            rise    = sn & ~m_srcq;
            m_epend = ((m_epend & ~clr) | rise) & m_mode;
            m_srcq  = sn;
        end
    end

    always @(negedge input_clk) begin
        if (!reset) begin
            check("model_cpu_irq", {31'd0, cpu_irq}, {31'd0, m_irq});
            check("model_rdata", bus.rdata, m_rdata);
        end
    end

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.select = 1'b1; bus.rd = 1'b1; bus.addr = a;
        @(posedge input_clk); #2;
        bus.select = 1'b0; bus.rd = 1'b0;
        d = bus.rdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.select = 1'b1; bus.we = 4'hF; bus.addr = a; bus.wdata = d;
        @(posedge input_clk); #2;
        bus.select = 1'b0; bus.we = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge input_clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_seq [3];
`ifdef IRQ_ROTATE_PRIORITY_EN
        exp_seq = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0001};
`else
        exp_seq = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
`endif
        reset = 1'b1; src = '0;
        bus.select = 1'b0; bus.rd = 1'b0; bus.we = 4'h0; bus.addr = 2'd0; bus.wdata = 32'd0;
        idle(3);
        reset = 1'b0;
        idle(1);

        check("reset_cpu_irq", {31'd0, cpu_irq}, 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        bus_read(2'd0, rd_val); check("reset_pending", rd_val, 32'd0);
        bus_read(2'd1, rd_val); check("reset_enable", rd_val, 32'd0);
        bus_read(2'd3, rd_val); check("reset_mode", rd_val, 32'd0);
        bus_read(2'd2, rd_val); check("reset_claim", rd_val, 32'd0);

        // Edge source 0: one-cycle pulse, claim, complete.
        bus_write(2'd3, 32'h01);
        bus_write(2'd1, 32'h01);
        src = 8'h01;
        idle(1); src = 8'h00;
        check("edge_irq_first_edge", {31'd0, cpu_irq}, 32'd0);
        idle(1);
        check("edge_irq_second_edge", {31'd0, cpu_irq}, 32'd1);
        bus_read(2'd0, rd_val); check("edge_pending", rd_val, 32'h1);
        bus_read(2'd2, rd_val); check("edge_claim", rd_val, 32'h8000_0000);
        idle(1);
        check("edge_irq_dropped", {31'd0, cpu_irq}, 32'd0);
        bus_read(2'd0, rd_val); check("edge_pending_cleared", rd_val, 32'h0);
        bus_write(2'd2, 32'd0);
        idle(2);
        check("edge_irq_after_complete", {31'd0, cpu_irq}, 32'd0);
        bus_read(2'd2, rd_val); check("edge_claim_idle", rd_val, 32'd0);

        // Level sources 1 and 3 held high.
        bus_write(2'd3, 32'h00);
        bus_write(2'd1, 32'h0A);
        src = 8'h0A;
        idle(2);
        for (int i = 0; i < 3; i++) begin
            bus_read(2'd2, rd_val);
            check("level_claim_seq", rd_val, exp_seq[i]);
            bus_write(2'd2, {27'd0, rd_val[4:0]});
        end

        // Wrong-index complete is ignored.
        bus_write(2'd1, 32'h04);
        src = 8'h04;
        idle(2);
        bus_read(2'd2, rd_val); check("wrong_idx_claim", rd_val, 32'h8000_0002);
        src = 8'h00;
        bus_write(2'd2, 32'd5);
        idle(2);
        check("wrong_idx_irq", {31'd0, cpu_irq}, 32'd0);
        bus_read(2'd2, rd_val); check("wrong_idx_still_busy", rd_val, 32'h8000_0002);
        bus_write(2'd2, 32'd2);
        idle(1);

        // Edge on source 4 in the same cycle as its W1C: set wins.
        bus_write(2'd3, 32'h10);
        src = 8'h10;
        bus_write(2'd0, 32'h10);
        bus_read(2'd0, rd_val); check("w1c_race_set_wins", rd_val, 32'h10);
        bus_write(2'd0, 32'h10);
        bus_read(2'd0, rd_val); check("w1c_clears", rd_val, 32'h0);
        src = 8'h00;
        idle(1);

        // Reset while in service with another source pending.
        bus_write(2'd1, 32'h30);
        src = 8'h30;
        idle(2);
        bus_read(2'd2, rd_val); check("pre_reset_claim", rd_val, 32'h8000_0004);
        idle(1);
        bus_read(2'd0, rd_val); check("pre_reset_pending", rd_val, 32'h20);
        reset = 1'b1; src = 8'h00;
        idle(1);
        reset = 1'b0;
        idle(1);
        check("post_reset_cpu_irq", {31'd0, cpu_irq}, 32'd0);
        check("post_reset_rdata", bus.rdata, 32'd0);
        bus_read(2'd0, rd_val); check("post_reset_pending", rd_val, 32'd0);
        bus_read(2'd1, rd_val); check("post_reset_enable", rd_val, 32'd0);
        bus_read(2'd3, rd_val); check("post_reset_mode", rd_val, 32'd0);
        bus_read(2'd2, rd_val); check("post_reset_claim", rd_val, 32'd0);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
